// File: rtl/ctrl_pipeline_if.sv
// Decoder-to-pipeline control interface: D-stage control word in, EX/MEM/WB state and hazard outputs back.
// Optional stall_count member present when CTRL_PIPELINE_STALL_CNT_EN is defined.
interface ctrl_pipeline_if #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned REG_AW = 5
`ifdef CTRL_PIPELINE_STALL_CNT_EN
  , parameter int unsigned STALL_CNT_W = 16
`endif
);
  logic [CTRL_W-1:0] ctrl_in;
  logic              ctrl_valid;
  logic              hold;
  logic              stall;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic              ex_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
`ifdef CTRL_PIPELINE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output ctrl_in, ctrl_valid, hold,
    input  stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
    input  fwd_a, fwd_b, wb_we, wb_rd, stall_count
  );
  modport slave (
    input  ctrl_in, ctrl_valid, hold,
    output stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
    output fwd_a, fwd_b, wb_we, wb_rd, stall_count
  );
`else
  modport master (
    output ctrl_in, ctrl_valid, hold,
    input  stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
    input  fwd_a, fwd_b, wb_we, wb_rd
  );
  modport slave (
    input  ctrl_in, ctrl_valid, hold,
    output stall, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
    output fwd_a, fwd_b, wb_we, wb_rd
  );
`endif
endinterface

// File: rtl/ctrl_pipeline.sv
// MIPS control-word pipeline (EX/MEM/WB) with load-use stall, operand forwarding selects and WB strobe.
// Define CTRL_PIPELINE_STALL_CNT_EN to add a saturating stall_count output.
module ctrl_pipeline #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned REG_AW = 5
`ifdef CTRL_PIPELINE_STALL_CNT_EN
  , parameter int unsigned STALL_CNT_W = 16
`endif
) (
  input logic           clk,
  input logic           rst_n,
  ctrl_pipeline_if.slave bus
);

  localparam int unsigned RS_LSB  = 19;
  localparam int unsigned RT_LSB  = 14;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned WE_BIT  = 6;
  localparam int unsigned ALU_BIT = 5;
  localparam int unsigned WB_BIT  = 3;
  localparam int unsigned ST_BIT  = 0;
  localparam logic [CTRL_W-1:0] KEEP_MASK = CTRL_W'(32'h00FF_FFFF);

  logic [CTRL_W-1:0] ex_q, mem_q, wb_q;
  logic              ex_v_q, mem_v_q, wb_v_q;

  logic [REG_AW-1:0] d_rs, d_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd_f;
  logic              d_uses_rt, ex_uses_rt;
  logic              ex_load, mem_writes, mem_load, wb_writes;
  logic              stall_c;
  logic [1:0]        fwd_a_c, fwd_b_c;

  assign d_rs    = bus.ctrl_in[RS_LSB +: REG_AW];
  assign d_rt    = bus.ctrl_in[RT_LSB +: REG_AW];
  assign ex_rs   = ex_q[RS_LSB +: REG_AW];
  assign ex_rt   = ex_q[RT_LSB +: REG_AW];
  assign ex_rd   = ex_q[RD_LSB +: REG_AW];
  assign mem_rd  = mem_q[RD_LSB +: REG_AW];
  assign wb_rd_f = wb_q[RD_LSB +: REG_AW];

  // rt is a real source only for ALU-immediate-free ops and stores
  assign d_uses_rt  = bus.ctrl_in[ALU_BIT] | bus.ctrl_in[ST_BIT];
  assign ex_uses_rt = ex_q[ALU_BIT] | ex_q[ST_BIT];

  assign ex_load    = ex_v_q & ex_q[WE_BIT] & (ex_rd != '0) & ex_q[WB_BIT];
  assign mem_writes = mem_v_q & mem_q[WE_BIT] & (mem_rd != '0);
  assign mem_load   = mem_writes & mem_q[WB_BIT];
  assign wb_writes  = wb_v_q & wb_q[WE_BIT] & (wb_rd_f != '0);

  assign stall_c = bus.ctrl_valid & ex_load &
                   ((d_rs == ex_rd) | (d_uses_rt & (d_rt == ex_rd)));

  // Forwarding selects: MEM result beats WB result; loads in MEM never forward
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (mem_writes && !mem_load && (ex_rs == mem_rd)) begin
      fwd_a_c = 2'b01;
    end else if (wb_writes && (ex_rs == wb_rd_f)) begin
      fwd_a_c = 2'b10;
    end
    if (ex_uses_rt) begin
      if (mem_writes && !mem_load && (ex_rt == mem_rd)) begin
        fwd_b_c = 2'b01;
      end else if (wb_writes && (ex_rt == wb_rd_f)) begin
        fwd_b_c = 2'b10;
      end
    end
  end

  // Stage registers; a stall turns the EX entry into a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
    end else if (!bus.hold) begin
      wb_q    <= mem_q;
      wb_v_q  <= mem_v_q;
      mem_q   <= ex_q;
      mem_v_q <= ex_v_q;
      if (stall_c) begin
        ex_q   <= '0;
        ex_v_q <= 1'b0;
      end else begin
        ex_q   <= bus.ctrl_in & KEEP_MASK;
        ex_v_q <= bus.ctrl_valid;
      end
    end
  end

`ifdef CTRL_PIPELINE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!bus.hold && stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt_q;
`endif

  assign bus.stall     = stall_c;
  assign bus.fwd_a     = fwd_a_c;
  assign bus.fwd_b     = fwd_b_c;
  assign bus.ex_ctrl   = ex_q;
  assign bus.mem_ctrl  = mem_q;
  assign bus.wb_ctrl   = wb_q;
  assign bus.ex_valid  = ex_v_q;
  assign bus.mem_valid = mem_v_q;
  assign bus.wb_valid  = wb_v_q;
  assign bus.wb_we     = wb_writes;
  assign bus.wb_rd     = wb_writes ? wb_rd_f : '0;

endmodule
